int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller sitting between the peripheral interrupt sources (timer, UART, button, spares) and the CPU's single interrupt request path.
- Synchronizes, latches, masks and priority-arbitrates up to 8 sources.
- Presents one request plus a source ID to the CPU and sequences the ack / end-of-interrupt handshake.
- Configured by the CPU through a 4-word, 16-bit register window decoded by the bus.

Parameters:
- N_SRC, 8, number of interrupt sources (1..8); unused index bits read 0.
- DATA_W, 16, register data width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- irq_src  in  N_SRC  raw interrupt lines, asynchronous; bit0 is timer, bit1 UART, bit2 button.
- reg_sel  in  1  register window selected by bus decode.
- reg_we  in  1  write strobe, qualified by reg_sel.
- reg_addr  in  2  word offset.
- reg_wdata  in  DATA_W  write data.
- reg_rdata  out  DATA_W  read data, combinational from reg_addr.
- irq_req  out  1  interrupt request to CPU.
- irq_id  out  3  index of the requesting source; valid while irq_req=1 and through service.
- irq_ack  in  1  one-cycle pulse: CPU has taken the vector.
- irq_eoi  in  1  one-cycle pulse: CPU has executed the return from interrupt.

Behaviour:
- Reset values: irq_req=0, irq_id=0, reg_rdata=0 (for reg_sel=0); PEND=0, MASK=0, EDGE=all ones, GIE=0; FSM in IDLE; synchronizers cleared.
- Input path: 2-flop synchronizer per source, then a third delay flop. Edge event = s2 & ~s3.
- Edge-mode sources (EDGE bit=1): PEND bit set on edge event and held until cleared.
- Level-mode sources (EDGE bit=0): PEND bit equals s2.
- Latency: a source high at clock edge k sets PEND at edge k+2. irq_req rises at edge k+3 if the source is eligible and the FSM is in IDLE.
- Registers:
  - offset 0 PEND: read; write-1-to-clear, edge bits only.
  - offset 1 MASK: read/write; 1 = enabled.
  - offset 2 EDGE: read/write.
  - offset 3 STATUS: bit0 GIE (read/write); bit1 in_service (read-only); bits4:2 irq_id (read-only).
  - Unused bits read 0. reg_rdata = 0 when reg_sel=0.
- Eligible vector = PEND & MASK, gated by GIE. Fixed priority: lowest index wins.
- FSM:
  - IDLE: if eligible != 0, latch winner into irq_id, assert irq_req → REQ.
  - REQ: irq_id frozen; no preemption, even by a higher-priority arrival.
    - On irq_ack: irq_req=0 and → SERVICE. If the source is edge-mode, its PEND bit is cleared in the same edge.
    - If the latched source stops being eligible before ack (W1C, level drop, MASK or GIE cleared): irq_req=0 next edge → IDLE.
  - SERVICE: in_service=1; irq_req held 0 regardless of new pending. On irq_eoi → IDLE, in_service=0. Re-arbitration happens on the following cycle.
- Boundary rules:
  - Edge event and W1C to the same bit in the same cycle: set wins.
  - Two edge events on one source before service collapse into one pending.
  - irq_ack outside REQ: ignored. irq_eoi outside SERVICE: ignored.
  - irq_ack and loss of eligibility in the same cycle: ack wins.
  - MASK/GIE writes during SERVICE do not abort service.
  - Writes to EDGE take effect the next cycle. Switching a bit to level mode makes PEND follow the line immediately.
  - Reset asserted mid-operation: all state returns to reset values asynchronously. irq_req drops without waiting for the handshake.

Test Plan:
- Reset, write MASK=0x01, STATUS=0x0001. Pulse irq_src[0] high at edge k → PEND=0x0001 at k+2, irq_req=1 with irq_id=0 at k+3. irq_ack → irq_req=0, PEND=0, STATUS reads 0x0003. irq_eoi → STATUS reads 0x0001.
- MASK=0x07, GIE=1. Raise src[2] and src[1] in the same cycle → irq_id=1 first. After ack+eoi, irq_id=2 is requested within 2 cycles.
- In REQ for id=2, raise src[0] → irq_id stays 2 until ack. After eoi, id 0 is served.
- In REQ for id=1, write PEND=0x0002 (W1C) → irq_req=0 next cycle, FSM IDLE, no ack required.
- EDGE=0xFE with src[0] held high: after ack+eoi, irq_req re-asserts (level). With EDGE=0xFF and src[0] held high, no second request.
- Drop rst_n during SERVICE → irq_req=0, MASK=0, EDGE=0xFF and STATUS=0 immediately. No stale request after reset release.

Source files
------------

// File: rtl/int_ctrl_if.sv
// Bus and interrupt-handshake bundle between the CPU/peripheral side and int_ctrl.
// The master side drives sources, register accesses and ack/eoi; the slave side is the controller.
interface int_ctrl_if #(
    parameter int N_SRC  = 8,
    parameter int DATA_W = 16
);
    logic [N_SRC-1:0]  irq_src;
    logic              reg_sel;
    logic              reg_we;
    logic [1:0]        reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] reg_rdata;
    logic              irq_req;
    logic [2:0]        irq_id;
    logic              irq_ack;
    logic              irq_eoi;

    modport master (
        output irq_src, reg_sel, reg_we, reg_addr, reg_wdata, irq_ack, irq_eoi,
        input  reg_rdata, irq_req, irq_id
    );

    modport slave (
        input  irq_src, reg_sel, reg_we, reg_addr, reg_wdata, irq_ack, irq_eoi,
        output reg_rdata, irq_req, irq_id
    );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt controller: synchronizes, latches, masks and fixed-priority arbitrates up to
// 8 sources, then sequences a single request through the CPU ack / end-of-interrupt handshake.
module int_ctrl #(
    parameter int N_SRC  = 8,
    parameter int DATA_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    int_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [N_SRC-1:0]  s1_reg, s2_reg, s3_reg;
    logic [N_SRC-1:0]  pend_reg, mask_reg, edge_reg;
    logic              gie_reg;
    logic              irq_req_reg;
    logic [2:0]        irq_id_reg;

    logic [N_SRC-1:0]  edge_evt;
    logic [N_SRC-1:0]  pend;
    logic [N_SRC-1:0]  eligible;
    logic [7:0]        eligible8;
    logic [N_SRC-1:0]  w1c;
    logic [N_SRC-1:0]  ack_clr;
    logic [N_SRC-1:0]  pend_next;
    logic [2:0]        winner_id;
    logic              wr_en;
    logic              wr_pend, wr_mask, wr_edge, wr_status;
    logic              ack_take;
    logic              in_service;
    logic              unused_wdata;

    assign wr_en     = bus.reg_sel & bus.reg_we;
    assign wr_pend   = wr_en && (bus.reg_addr == 2'd0);
    assign wr_mask   = wr_en && (bus.reg_addr == 2'd1);
    assign wr_edge   = wr_en && (bus.reg_addr == 2'd2);
    assign wr_status = wr_en && (bus.reg_addr == 2'd3);

    assign unused_wdata = ^bus.reg_wdata[DATA_W-1:N_SRC];

    assign in_service = (state_reg == SERVICE);
    assign ack_take   = (state_reg == REQ) && bus.irq_ack;

    assign edge_evt = s2_reg & ~s3_reg;
    // Level-mode bits read straight from the synchronized line; edge-mode bits from the latch.
    assign pend     = (pend_reg & edge_reg) | (s2_reg & ~edge_reg);
    assign eligible = pend & mask_reg & {N_SRC{gie_reg}};

    always_comb begin
        eligible8 = '0;
        eligible8[N_SRC-1:0] = eligible;
    end

    // Scan downward so the lowest active index is the last to overwrite.
    always_comb begin
        winner_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_id = 3'(i);
            end
        end
    end

    // Per-source latch: a new edge beats both W1C and the ack clear in the same cycle.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign w1c[gi]       = wr_pend & bus.reg_wdata[gi];
            assign ack_clr[gi]   = ack_take && (irq_id_reg == 3'(gi));
            assign pend_next[gi] = edge_reg[gi] &
                                   (edge_evt[gi] | (pend_reg[gi] & ~w1c[gi] & ~ack_clr[gi]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            s3_reg   <= '0;
            pend_reg <= '0;
        end else begin
            s1_reg   <= bus.irq_src;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            pend_reg <= pend_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_reg <= '0;
            edge_reg <= '1;
            gie_reg  <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask_reg <= bus.reg_wdata[N_SRC-1:0];
            end
            if (wr_edge) begin
                edge_reg <= bus.reg_wdata[N_SRC-1:0];
            end
            if (wr_status) begin
                gie_reg <= bus.reg_wdata[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            irq_req_reg <= 1'b0;
            irq_id_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|eligible) begin
                        irq_id_reg  <= winner_id;
                        irq_req_reg <= 1'b1;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over a same-cycle loss of eligibility.
                    if (bus.irq_ack) begin
                        irq_req_reg <= 1'b0;
                        state_reg   <= SERVICE;
                    end else if (!eligible8[irq_id_reg]) begin
                        irq_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                    end
                end
                SERVICE: begin
                    irq_req_reg <= 1'b0;
                    if (bus.irq_eoi) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    irq_req_reg <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.reg_rdata = '0;
        if (bus.reg_sel) begin
            case (bus.reg_addr)
                2'd0: bus.reg_rdata[N_SRC-1:0] = pend;
                2'd1: bus.reg_rdata[N_SRC-1:0] = mask_reg;
                2'd2: bus.reg_rdata[N_SRC-1:0] = edge_reg;
                default: begin
                    bus.reg_rdata[0]   = gie_reg;
                    bus.reg_rdata[1]   = in_service;
                    bus.reg_rdata[4:2] = irq_id_reg;
                end
            endcase
        end
    end

    assign bus.irq_req = irq_req_reg;
    assign bus.irq_id  = irq_id_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl: linear stimulus with hand-computed expectations,
// checked by immediate assertions.
module tb_int_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    int_ctrl_if #(.N_SRC(8), .DATA_W(16)) bus_if ();

    int_ctrl #(.N_SRC(8), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
        bus_if.reg_sel   = 1'b1;
        bus_if.reg_we    = 1'b1;
        bus_if.reg_addr  = a;
        bus_if.reg_wdata = d;
        tick(1);
        bus_if.reg_sel   = 1'b0;
        bus_if.reg_we    = 1'b0;
        bus_if.reg_wdata = '0;
    endtask

    task automatic check_rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_if.reg_sel  = 1'b1;
        bus_if.reg_we   = 1'b0;
        bus_if.reg_addr = a;
        #1;
        d = bus_if.reg_rdata;
        bus_if.reg_sel  = 1'b0;
        check(tag, d, exp);
    endtask

    task automatic check_req(input string tag, input logic req, input logic [2:0] id);
        check({tag, "_req"}, {15'd0, bus_if.irq_req}, {15'd0, req});
        if (req) begin
            check({tag, "_id"}, {13'd0, bus_if.irq_id}, {13'd0, id});
        end
    endtask

    task automatic pulse_ack();
        bus_if.irq_ack = 1'b1;
        tick(1);
        bus_if.irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus_if.irq_eoi = 1'b1;
        tick(1);
        bus_if.irq_eoi = 1'b0;
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        rst_n            = 1'b0;
        bus_if.irq_src   = '0;
        bus_if.reg_sel   = 1'b0;
        bus_if.reg_we    = 1'b0;
        bus_if.reg_addr  = '0;
        bus_if.reg_wdata = '0;
        bus_if.irq_ack   = 1'b0;
        bus_if.irq_eoi   = 1'b0;
        tick(3);

        // Reset state
        check_req("rst", 1'b0, 3'd0);
        check("rst_id", {13'd0, bus_if.irq_id}, 16'h0000);
        check("rst_rdata_nosel", bus_if.reg_rdata, 16'h0000);
        check_rd("rst_pend", 2'd0, 16'h0000);
        check_rd("rst_mask", 2'd1, 16'h0000);
        check_rd("rst_edge", 2'd2, 16'h00FF);
        check_rd("rst_status", 2'd3, 16'h0000);
        rst_n = 1'b1;
        tick(1);

        // Single edge source: latency and full handshake
        reg_wr(2'd1, 16'h0001);
        reg_wr(2'd3, 16'h0001);
        bus_if.irq_src = 8'h01;
        tick(1);
        check_rd("t1_pend_k", 2'd0, 16'h0000);
        tick(1);
        check_rd("t1_pend_k1", 2'd0, 16'h0000);
        tick(1);
        check_rd("t1_pend_k2", 2'd0, 16'h0001);
        check_req("t1_k2", 1'b0, 3'd0);
        tick(1);
        check_req("t1_k3", 1'b1, 3'd0);
        bus_if.irq_src = 8'h00;
        pulse_ack();
        check_req("t1_ack", 1'b0, 3'd0);
        check_rd("t1_ack_pend", 2'd0, 16'h0000);
        check_rd("t1_ack_status", 2'd3, 16'h0003);
        pulse_eoi();
        check_rd("t1_eoi_status", 2'd3, 16'h0001);
        tick(1);
        check_req("t1_idle", 1'b0, 3'd0);

        // Simultaneous sources: lowest index first, then the next within 2 cycles
        reg_wr(2'd1, 16'h0007);
        bus_if.irq_src = 8'h06;
        tick(4);
        check_req("t2_first", 1'b1, 3'd1);
        bus_if.irq_src = 8'h00;
        pulse_ack();
        check_rd("t2_ack_pend", 2'd0, 16'h0004);
        pulse_eoi();
        tick(1);
        check_req("t2_second", 1'b1, 3'd2);

        // Higher-priority arrival while in REQ does not preempt
        bus_if.irq_src = 8'h01;
        tick(4);
        bus_if.irq_src = 8'h00;
        check_rd("t3_pend", 2'd0, 16'h0005);
        check_req("t3_frozen", 1'b1, 3'd2);
        pulse_ack();
        check_rd("t3_svc_status", 2'd3, 16'h000B);
        pulse_eoi();
        tick(1);
        check_req("t3_next", 1'b1, 3'd0);
        pulse_ack();
        pulse_eoi();
        tick(1);
        check_req("t3_done", 1'b0, 3'd0);
        check_rd("t3_pend_clear", 2'd0, 16'h0000);

        // Ack outside REQ is ignored
        pulse_ack();
        check_rd("t3b_stray_ack", 2'd3, 16'h0001);

        // W1C of the latched source while in REQ withdraws the request
        bus_if.irq_src = 8'h02;
        tick(4);
        bus_if.irq_src = 8'h00;
        check_req("t4_req", 1'b1, 3'd1);
        reg_wr(2'd0, 16'h0002);
        check_rd("t4_pend_w1c", 2'd0, 16'h0000);
        tick(1);
        check_req("t4_drop", 1'b0, 3'd0);
        tick(1);
        check_req("t4_stay_idle", 1'b0, 3'd0);
        check_rd("t4_status", 2'd3, 16'h0005);

        // Level mode re-requests while the line stays high; edge mode does not
        reg_wr(2'd2, 16'h00FE);
        bus_if.irq_src = 8'h01;
        tick(4);
        check_req("t5_lvl_req", 1'b1, 3'd0);
        pulse_ack();
        check_req("t5_lvl_ack", 1'b0, 3'd0);
        pulse_eoi();
        tick(1);
        check_req("t5_lvl_rereq", 1'b1, 3'd0);
        pulse_ack();
        reg_wr(2'd2, 16'h00FF);
        pulse_eoi();
        tick(3);
        check_req("t5_edge_noreq", 1'b0, 3'd0);
        check_rd("t5_edge_pend", 2'd0, 16'h0000);
        bus_if.irq_src = 8'h00;
        tick(3);

        // Asynchronous reset in the middle of service
        bus_if.irq_src = 8'h04;
        tick(4);
        bus_if.irq_src = 8'h00;
        check_req("t6_req", 1'b1, 3'd2);
        pulse_ack();
        check_rd("t6_svc_status", 2'd3, 16'h000B);
        #1;
        rst_n = 1'b0;
        #1;
        check_req("t6_rst_req", 1'b0, 3'd0);
        check_rd("t6_rst_mask", 2'd1, 16'h0000);
        check_rd("t6_rst_edge", 2'd2, 16'h00FF);
        check_rd("t6_rst_status", 2'd3, 16'h0000);
        tick(2);
        rst_n = 1'b1;
        tick(5);
        check_req("t6_post_req", 1'b0, 3'd0);
        check_rd("t6_post_pend", 2'd0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
